ps2_dev: RTL and testbench
==========================

// Module: ps2_dev
// PURPOSE
//  Device-side PS/2 endpoint (keyboard/mouse emulator): generates PS/2 clock, sends bytes to host,
//  receives host commands with ack. Sits between a scan-code/report source and open-drain PS/2 pads.
//  Complement to the host-side PS/2 Wishbone controller; used for keyboard emulation and loopback test.
// PARAMETERS
//  CLK_HALF     2000  wb_clk_i cycles per PS/2 clock half-period (2000 @50MHz = 12.5kHz)
//  IDLE_CYCLES  2500  cycles clk+dat must both read high before starting a device->host frame
//  TX_FIFO_AW   2     log2 TX FIFO depth (used only with PS2_DEV_TX_FIFO_EN)
// PORTS
//  wb_clk_i      in   1  clock, sole clock domain
//  wb_rst_i      in   1  reset, asynchronous, active-high
//  tx_data_i     in   8  byte to send to host
//  tx_valid_i    in   1  tx handshake: byte accepted when tx_valid_i & tx_ready_o
//  tx_ready_o    out  1  can accept a byte
//  rx_data_o     out  8  last host command byte; held until next reception
//  rx_valid_o    out  1  one-cycle pulse, rx_data_o/rx_err_o valid
//  rx_err_o      out  1  with rx_valid_o: parity or stop-bit error
//  busy_o        out  1  frame in progress (either direction)
//  ps2_clk_i     in   1  PS/2 clock pad input
//  ps2_clk_oe_o  out  1  1 = drive PS/2 clock low, 0 = release
//  ps2_dat_i     in   1  PS/2 data pad input
//  ps2_dat_oe_o  out  1  1 = drive PS/2 data low, 0 = release
// BEHAVIOUR
//  Reset: all outputs 0 except tx_ready_o=1; pads released; reset mid-frame aborts, nothing retried.
//  Pad inputs: 2-flop sync; all decisions use synced values (2-cycle input latency).
//  Bit timing: divider counts CLK_HALF per half; a pulse = HIGH half (released) then LOW half (driven).
//  States: IDLE, TX_WAIT, TX, RX, RX_ACK, HOLD.
//  IDLE: synced clk=1 & dat=0 -> RX (host request-to-send; beats pending TX).
//        byte pending -> TX_WAIT. tx_ready_o=1 only in IDLE with no byte held.
//  TX_WAIT: idle counter runs while clk&dat high, clears otherwise; reaching IDLE_CYCLES -> TX.
//  TX: 11 bits: start 0, d[0..7] LSB first, odd parity, stop 1. Data pad set at start of HIGH half;
//      host samples on our falling edge. After bit 10's LOW half -> HOLD, byte consumed.
//  Inhibit: in TX, synced clk=0 during a HIGH half (after 2-cycle sync settle) -> release both pads
//      next cycle, keep byte, -> TX_WAIT; whole frame resent. Inhibit in IDLE/TX_WAIT just delays.
//  RX: 10 pulses; dat sampled on last cycle of each HIGH half: d[0..7], parity, stop.
//      Stop=1 -> RX_ACK; stop=0 -> frame error: rx_valid_o+rx_err_o=1, no ack, -> HOLD.
//  RX_ACK: drive dat low for one full pulse (HIGH+LOW), release; rx_valid_o pulses on release,
//      rx_err_o=1 if parity even. -> HOLD.
//  HOLD: one CLK_HALF with pads released, then IDLE. busy_o=1 in every state except IDLE.
//  Parity: odd; parity bit = ~^data.
//  Simultaneous tx_valid_i and host RTS in IDLE: byte accepted (if ready) but RX runs first.
// CONFIGURATION
//  PS2_DEV_TX_FIFO_EN defined: 2**TX_FIFO_AW-entry FIFO on TX path; tx_ready_o = !full;
//      accepts in any state; bytes sent in order; inhibited byte remains at head.
//  Undefined: single holding register; tx_ready_o only in IDLE with register empty.
// STRUCTURE
//  Include ps2_dev_defs.vh: state encodings, frame length 11, RX pulse count 10, counter width 16.
//  Sub-module ps2_dev_fifo (sync FIFO, params DW=8, AW) instantiated only under PS2_DEV_TX_FIFO_EN.
//  Remainder (sync, divider, FSM, shift regs) is flat in ps2_dev.
// TESTING (CLK_HALF=4, IDLE_CYCLES=8 in bench)
//  Send 0x1C -> host model sees 0,0,0,1,1,1,0,0,0,0(parity),1; tx_ready_o back high after HOLD.
//  Host RTS + 0xFF, parity 1, stop 1 -> 10 pulses, dat low on pulse 11, rx_valid_o, rx_data_o=0xFF, err=0.
//  Host sends 0xED with parity 0 -> ack still driven, rx_valid_o with rx_err_o=1, rx_data_o=0xED.
//  Host sends 0x55, stop bit 0 -> no ack pulse, rx_valid_o with rx_err_o=1, back to IDLE.
//  Send 0xAA, host pulls clk low in bit 4 -> pads released within 3 cycles; after release+8 idle,
//      full 0xAA frame resent, ready only after completion.
//  Assert wb_rst_i mid-TX -> oe outputs 0 same cycle (async), no retransmit; with FIFO_EN push 5 into
//      depth 4 -> 5th stalls on tx_ready_o=0, all 4 sent in order.

Source files
------------

// File: rtl/ps2_dev_pkg.sv
// Shared definitions for the PS/2 device endpoint: FSM encoding, frame geometry, counter width.
package ps2_dev_pkg;

    localparam int unsigned CNT_W         = 16;
    localparam int unsigned BIT_W         = 4;
    localparam int unsigned TX_FRAME_BITS = 11;
    localparam int unsigned RX_PULSES     = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_WAIT = 3'd1,
        ST_TX      = 3'd2,
        ST_RX      = 3'd3,
        ST_RX_ACK  = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    // Device->host frame, index 0 goes on the wire first: start, data LSB first, odd parity, stop.
    function automatic logic [TX_FRAME_BITS-1:0] tx_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_dev_fifo.sv
// Small synchronous FIFO holding bytes queued for transmission to the host.
module ps2_dev_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          do_wr, do_rd;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en_i & ~full_o;
    assign do_rd   = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/ps2_dev.sv
// Device-side PS/2 endpoint: generates the PS/2 clock, sends bytes to the host, receives host commands.
// Define PS2_DEV_TX_FIFO_EN to replace the single TX holding register with a FIFO of 2**TX_FIFO_AW bytes.
module ps2_dev
    import ps2_dev_pkg::*;
#(
    parameter int unsigned CLK_HALF    = 2000,
    parameter int unsigned IDLE_CYCLES = 2500
`ifdef PS2_DEV_TX_FIFO_EN
    ,
    parameter int unsigned TX_FIFO_AW  = 2
`endif
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_err_o,
    output logic       busy_o,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe_o,
    input  logic       ps2_dat_i,
    output logic       ps2_dat_oe_o
);

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, idle_q, idle_d;
    logic               phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [9:0]         rx_sh_q, rx_sh_d;
    logic               clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d, busy_q, busy_d;
    logic               rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    logic [7:0]         rx_data_q, rx_data_d;

    logic               half_end, pulse_end, sample, rts, inhibit;
    logic               tx_pend, tx_pop, rx_done, rx_fail;
    logic [7:0]         tx_byte;
    logic [15:0]        frame_ext;

    // Two-flop synchronisers; reset to the released (high) line level.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_i;
            dat_s2_q <= dat_s1_q;
        end
    end

`ifdef PS2_DEV_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    ps2_dev_fifo #(.DW(8), .AW(TX_FIFO_AW)) u_tx_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .wr_en_i   (tx_valid_i & ~fifo_full),
        .wr_data_i (tx_data_i),
        .rd_en_i   (tx_pop),
        .rd_data_o (tx_byte),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign tx_pend    = ~fifo_empty;
    assign tx_ready_o = ~fifo_full;
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d, tx_ready_q, tx_ready_d;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q & ~tx_pop;
        if (tx_valid_i & tx_ready_q) begin
            hold_d     = tx_data_i;
            hold_vld_d = 1'b1;
        end
        tx_ready_d = (state_d == ST_IDLE) & ~hold_vld_d;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx_pend    = hold_vld_q;
    assign tx_byte    = hold_q;
    assign tx_ready_o = tx_ready_q;
`endif

    assign half_end  = (cnt_q == CNT_W'(CLK_HALF - 1));
    assign pulse_end = half_end & phase_q;
    assign sample    = half_end & ~phase_q;
    assign rts       = clk_s2_q & ~dat_s2_q;
    // Synced clock needs two cycles after our release before a low level means the host holds it.
    assign inhibit   = ~phase_q & (cnt_q >= CNT_W'(2)) & ~clk_s2_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idle_q     <= '0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            rx_sh_q    <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            rx_sh_q    <= rx_sh_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        rx_sh_d = rx_sh_q;
        tx_pop  = 1'b0;
        rx_done = 1'b0;
        rx_fail = 1'b0;
        cnt_d   = half_end ? '0 : cnt_q + CNT_W'(1);
        phase_d = phase_q ^ half_end;
        bit_d   = bit_q + BIT_W'(pulse_end);
        unique case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                idle_d  = '0;
                if (rts)          state_d = ST_RX;
                else if (tx_pend) state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                // A host that inhibited us may follow up with its own request-to-send.
                if (rts) begin
                    state_d = ST_RX;
                    idle_d  = '0;
                end else if (clk_s2_q & dat_s2_q) begin
                    idle_d = idle_q + CNT_W'(1);
                    if (idle_d == CNT_W'(IDLE_CYCLES)) state_d = ST_TX;
                end else begin
                    idle_d = '0;
                end
            end
            ST_TX: begin
                if (inhibit) begin
                    state_d = ST_TX_WAIT;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    idle_d  = '0;
                end else if (pulse_end && bit_q == BIT_W'(TX_FRAME_BITS - 1)) begin
                    state_d = ST_HOLD;
                    tx_pop  = 1'b1;
                end
            end
            ST_RX: begin
                if (sample) rx_sh_d = {dat_s2_q, rx_sh_q[9:1]};
                if (pulse_end && bit_q == BIT_W'(RX_PULSES - 1)) begin
                    if (rx_sh_q[9]) begin
                        state_d = ST_RX_ACK;
                    end else begin
                        state_d = ST_HOLD;
                        rx_fail = 1'b1;
                    end
                end
            end
            ST_RX_ACK: begin
                if (pulse_end) begin
                    state_d = ST_HOLD;
                    rx_done = 1'b1;
                end
            end
            ST_HOLD: begin
                if (half_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad drives follow the next state so they change on the same edge as the FSM.
    always_comb begin
        frame_ext  = 16'(tx_frame(tx_byte));
        clk_oe_d   = (state_d inside {ST_TX, ST_RX, ST_RX_ACK}) & phase_d;
        dat_oe_d   = 1'b0;
        if (state_d == ST_TX)          dat_oe_d = ~frame_ext[bit_d];
        else if (state_d == ST_RX_ACK) dat_oe_d = 1'b1;
        busy_d     = (state_d != ST_IDLE);
        rx_valid_d = rx_done | rx_fail;
        rx_err_d   = rx_fail | (rx_done & ~^rx_sh_q[8:0]);
        rx_data_d  = rx_valid_d ? rx_sh_q[7:0] : rx_data_q;
    end

    assign ps2_clk_oe_o = clk_oe_q;
    assign ps2_dat_oe_o = dat_oe_q;
    assign busy_o       = busy_q;
    assign rx_valid_o   = rx_valid_q;
    assign rx_err_o     = rx_err_q;
    assign rx_data_o    = rx_data_q;

endmodule

// File: tb/tb_ps2_dev.sv
// Directed bench for ps2_dev: open-drain pad model plus a simple PS/2 host model.
module tb_ps2_dev;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err, busy;
    logic       clk_oe, dat_oe;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;
    logic       pad_clk, pad_dat;

    int n_run  = 0;
    int n_fail = 0;

`ifdef PS2_DEV_TX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    assign pad_clk = ~(clk_oe | host_clk_low);
    assign pad_dat = ~(dat_oe | host_dat_low);

    always #5 clk = ~clk;

    ps2_dev #(.CLK_HALF(4), .IDLE_CYCLES(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_err_o     (rx_err),
        .busy_o       (busy),
        .ps2_clk_i    (pad_clk),
        .ps2_clk_oe_o (clk_oe),
        .ps2_dat_i    (pad_dat),
        .ps2_dat_oe_o (dat_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_pad_clk(input logic lvl, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (pad_clk == lvl) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic capture_frame(output logic [10:0] f, output bit ok, output int gap);
        bit ok1, ok2;
        int n1, n2;
        f   = '0;
        ok  = 1'b1;
        gap = 0;
        for (int i = 0; i < 11; i++) begin
            wait_pad_clk(1'b1, ok1, n1);
            wait_pad_clk(1'b0, ok2, n2);
            if (!(ok1 && ok2)) begin
                ok = 1'b0;
                return;
            end
            if (i == 0) gap = n1 + n2;
            f[i] = pad_dat;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_ready_timeout", 32'(ok), 32'd1);
        tx_data  = b;
        tx_valid = ok;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Host request-to-send followed by 10 host-driven bits; observes the ack pulse and rx outputs.
    task automatic host_frame(input logic [7:0] d, input logic par, input logic stop,
                              output int falls, output bit ack, output bit dev_dat,
                              output int vcnt, output logic [7:0] rdata, output bit rerr,
                              output bit done);
        logic [9:0] bits;
        bit         seen_busy = 1'b0;
        logic       prev;
        bits    = {stop, par, d};
        falls   = 0;
        ack     = 1'b0;
        dev_dat = 1'b0;
        vcnt    = 0;
        rdata   = '0;
        rerr    = 1'b0;
        done    = 1'b0;
        @(negedge clk);
        host_dat_low = 1'b1;
        prev = pad_clk;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!seen_busy && busy) begin
                seen_busy    = 1'b1;
                host_dat_low = ~bits[0];
            end
            if (prev && !pad_clk) begin
                falls++;
                if (falls <= 9) host_dat_low = ~bits[falls];
                else            host_dat_low = 1'b0;
                if (falls == 11) ack = ~pad_dat;
            end
            if (dat_oe) dev_dat = 1'b1;
            if (rx_valid) begin
                vcnt++;
                rdata = rx_data;
                rerr  = rx_err;
            end
            if (seen_busy && !busy) begin
                done = 1'b1;
                break;
            end
            prev = pad_clk;
        end
        host_dat_low = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        logic [7:0]  rd;
        bit          ok, ack, ddrv, rerr, done;
        int          gap, falls, vcnt, rel, n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_outputs", 32'({busy, rx_valid, rx_err, clk_oe, dat_oe}), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);

        // Device -> host: 0x1C, parity 0
        send_byte(8'h1C);
        check("tx_1c_ready_during", 32'(tx_ready), 32'(FIFO_EN));
        capture_frame(f, ok, gap);
        check("tx_1c_capture_ok", 32'(ok), 32'd1);
        check("tx_1c_frame", 32'(f), 32'h438);
        wait_idle(ok);
        check("tx_1c_idle", 32'(ok), 32'd1);
        check("tx_1c_ready_after", 32'(tx_ready), 32'd1);

        // Host -> device: 0xFF, good parity, good stop
        host_frame(8'hFF, 1'b1, 1'b1, falls, ack, ddrv, vcnt, rd, rerr, done);
        check("rx_ff_done", 32'(done), 32'd1);
        check("rx_ff_pulses", 32'(falls), 32'd11);
        check("rx_ff_ack", 32'(ack), 32'd1);
        check("rx_ff_valid_cnt", 32'(vcnt), 32'd1);
        check("rx_ff_data", 32'(rd), 32'hFF);
        check("rx_ff_err", 32'(rerr), 32'd0);

        // Host -> device: 0xED with even parity
        host_frame(8'hED, 1'b0, 1'b1, falls, ack, ddrv, vcnt, rd, rerr, done);
        check("rx_ed_pulses", 32'(falls), 32'd11);
        check("rx_ed_ack", 32'(ack), 32'd1);
        check("rx_ed_data", 32'(rd), 32'hED);
        check("rx_ed_err", 32'(rerr), 32'd1);

        // Host -> device: 0x55 with bad stop bit
        host_frame(8'h55, 1'b1, 1'b0, falls, ack, ddrv, vcnt, rd, rerr, done);
        check("rx_55_done", 32'(done), 32'd1);
        check("rx_55_pulses", 32'(falls), 32'd10);
        check("rx_55_no_ack_drive", 32'(ddrv), 32'd0);
        check("rx_55_valid_cnt", 32'(vcnt), 32'd1);
        check("rx_55_data", 32'(rd), 32'h55);
        check("rx_55_err", 32'(rerr), 32'd1);
        @(negedge clk);
        check("rx_55_ready_idle", 32'(tx_ready), 32'd1);

        // Inhibit during data bit 4 of 0xAA, then full resend
        send_byte(8'hAA);
        for (int k = 0; k < 5; k++) begin
            wait_pad_clk(1'b1, ok, n);
            wait_pad_clk(1'b0, ok, n);
        end
        wait_pad_clk(1'b1, ok, n);
        check("inh_pre_dat_driven", 32'(dat_oe), 32'd1);
        host_clk_low = 1'b1;
        rel = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (!clk_oe && !dat_oe) begin
                rel = c;
                break;
            end
        end
        check("inh_release_cycles", 32'(rel >= 1 && rel <= 3), 32'd1);
        repeat (20) @(negedge clk);
        check("inh_busy_held", 32'(busy), 32'd1);
        check("inh_ready_held", 32'(tx_ready), 32'(FIFO_EN));
        host_clk_low = 1'b0;
        capture_frame(f, ok, gap);
        check("inh_resend_ok", 32'(ok), 32'd1);
        check("inh_resend_gap", 32'(gap >= 12 && gap <= 20), 32'd1);
        check("inh_resend_frame", 32'(f), 32'h754);
        check("inh_ready_before_end", 32'(tx_ready), 32'(FIFO_EN));
        wait_idle(ok);
        check("inh_ready_after", 32'(tx_ready), 32'd1);

        // Asynchronous reset in the middle of a 0x00 frame
        send_byte(8'h00);
        for (int k = 0; k < 2; k++) begin
            wait_pad_clk(1'b1, ok, n);
            wait_pad_clk(1'b0, ok, n);
        end
        check("rst_pre_driving", 32'({clk_oe, dat_oe}), 32'h3);
        #2 rst = 1'b1;
        #1;
        check("rst_async_release", 32'({clk_oe, dat_oe}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        falls = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (clk_oe) falls++;
        end
        check("rst_no_retransmit", 32'(falls), 32'd0);
        check("rst_idle_ready", 32'({busy, tx_ready}), 32'h1);

`ifdef PS2_DEV_TX_FIFO_EN
        begin
            logic [7:0] fb [5];
            fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'h55;
            fork
                begin
                    for (int i = 0; i < 4; i++) send_byte(fb[i]);
                    check("fifo_full_ready", 32'(tx_ready), 32'd0);
                    send_byte(fb[4]);
                end
                begin
                    logic [10:0] ff;
                    bit          fok;
                    int          fgap;
                    for (int i = 0; i < 5; i++) begin
                        capture_frame(ff, fok, fgap);
                        check("fifo_frame", 32'(ff), 32'({2'b11, fb[i], 1'b0}));
                    end
                end
            join
            wait_idle(ok);
            check("fifo_drained_ready", 32'(tx_ready), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
